// File: rtl/matmul_sequencer_if.sv
// matmul_sequencer_if
// Bundles the start/busy handshake, the matrix descriptor and the shared
// single-port DRAM bus of the matrix-multiply sequencer.
//   master : the sequencer side. It drives o_busy, o_done and the DRAM strobes,
//            address and write data. It receives i_start, the dimensions,
//            the base addresses and the DRAM read data.
//   slave  : the host/DRAM side, with the opposite directions.
// Member names carry _i/_o as seen from the sequencer.
interface matmul_sequencer_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int DIM_W  = 5
);
    logic              i_start;
    logic [DIM_W-1:0]  i_m;
    logic [DIM_W-1:0]  i_k;
    logic [DIM_W-1:0]  i_n;
    logic [ADDR_W-1:0] i_a_base;
    logic [ADDR_W-1:0] i_b_base;
    logic [ADDR_W-1:0] i_c_base;
    logic              o_busy;
    logic              o_done;
    logic              o_dram_read;
    logic              o_dram_write;
    logic [ADDR_W-1:0] o_dram_addr;
    logic [DATA_W-1:0] o_dram_wdata;
    logic [DATA_W-1:0] i_dram_rdata;

    modport master (
        input  i_start, i_m, i_k, i_n, i_a_base, i_b_base, i_c_base, i_dram_rdata,
        output o_busy, o_done, o_dram_read, o_dram_write, o_dram_addr, o_dram_wdata
    );

    modport slave (
        output i_start, i_m, i_k, i_n, i_a_base, i_b_base, i_c_base, i_dram_rdata,
        input  o_busy, o_done, o_dram_read, o_dram_write, o_dram_addr, o_dram_wdata
    );
endinterface

// File: rtl/matmul_sequencer.sv
// matmul_sequencer
// Control sequencer for C = A x B, with all matrices stored row-major in DRAM.
// On a rising edge of i_start it walks every element of C. For each term it
// reads A, then reads B, then accumulates the product. It writes each finished
// element back, truncated to DATA_W bits.
// Ports:
//   i_clk : clock, rising edge
//   i_rst : asynchronous active-high reset
//   bus   : matmul_sequencer_if.master (handshake, descriptor, DRAM bus)
// All outputs are registered. Their next values are decoded from the next
// state, so the strobe, address and data of a state appear exactly during
// that state's cycle.
module matmul_sequencer #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int DIM_W  = 5
) (
    input  logic               i_clk,
    input  logic               i_rst,
    matmul_sequencer_if.master bus
);
    localparam int ACC_W = 2 * DATA_W + DIM_W;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RD_A = 3'd1;
    localparam logic [2:0] ST_RD_B = 3'd2;
    localparam logic [2:0] ST_MAC  = 3'd3;
    localparam logic [2:0] ST_WR   = 3'd4;

    logic [2:0]        state_q, state_d;
    logic              start_q;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              read_q, read_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DIM_W-1:0]  m_q, m_d, k_q, k_d, n_q, n_d;
    logic [ADDR_W-1:0] a_base_q, a_base_d, b_base_q, b_base_d, c_base_q, c_base_d;
    logic [DIM_W-1:0]  i_q, i_d, j_q, j_d, t_q, t_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [DATA_W-1:0] opa_q, opa_d;
    logic              start_edge_s;

    // A run only begins on a low-to-high transition of the start level.
    assign start_edge_s = bus.i_start & ~start_q;

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        m_d      = m_q;
        k_d      = k_q;
        n_d      = n_q;
        a_base_d = a_base_q;
        b_base_d = b_base_q;
        c_base_d = c_base_q;
        i_d      = i_q;
        j_d      = j_q;
        t_d      = t_q;
        acc_d    = acc_q;
        opa_d    = opa_q;

        case (state_q)
            ST_IDLE: begin
                if (busy_q) begin
                    // Zero-dimension run: one busy cycle, then finish.
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end else if (start_edge_s) begin
                    m_d      = bus.i_m;
                    k_d      = bus.i_k;
                    n_d      = bus.i_n;
                    a_base_d = bus.i_a_base;
                    b_base_d = bus.i_b_base;
                    c_base_d = bus.i_c_base;
                    i_d      = '0;
                    j_d      = '0;
                    t_d      = '0;
                    acc_d    = '0;
                    busy_d   = 1'b1;
                    if ((bus.i_m == '0) || (bus.i_k == '0) || (bus.i_n == '0)) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_RD_A;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_A: begin
                state_d = ST_RD_B;
            end
            ST_RD_B: begin
                // The A element requested in RD_A is on the read bus now.
                opa_d   = bus.i_dram_rdata;
                state_d = ST_MAC;
            end
            ST_MAC: begin
                acc_d = acc_q + (ACC_W'(opa_q) * ACC_W'(bus.i_dram_rdata));
                if (t_q == (k_q - DIM_W'(1))) begin
                    state_d = ST_WR;
                end else begin
                    t_d     = t_q + DIM_W'(1);
                    state_d = ST_RD_A;
                end
            end
            ST_WR: begin
                acc_d = '0;
                t_d   = '0;
                if (j_q == (n_q - DIM_W'(1))) begin
                    j_d = '0;
                    if (i_q == (m_q - DIM_W'(1))) begin
                        i_d     = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        i_d     = i_q + DIM_W'(1);
                        state_d = ST_RD_A;
                    end
                end else begin
                    j_d     = j_q + DIM_W'(1);
                    state_d = ST_RD_A;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        read_d  = (state_d == ST_RD_A) || (state_d == ST_RD_B);
        write_d = (state_d == ST_WR);
        addr_d  = '0;
        wdata_d = '0;
        // Address arithmetic is modulo 2^ADDR_W by construction.
        case (state_d)
            ST_RD_A: addr_d = a_base_d + (ADDR_W'(i_d) * ADDR_W'(k_d)) + ADDR_W'(t_d);
            ST_RD_B: addr_d = b_base_d + (ADDR_W'(t_d) * ADDR_W'(n_d)) + ADDR_W'(j_d);
            ST_WR: begin
                addr_d  = c_base_d + (ADDR_W'(i_d) * ADDR_W'(n_d)) + ADDR_W'(j_d);
                wdata_d = acc_d[DATA_W-1:0];
            end
            default: begin
                addr_d  = '0;
                wdata_d = '0;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            start_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            read_q   <= 1'b0;
            write_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            m_q      <= '0;
            k_q      <= '0;
            n_q      <= '0;
            a_base_q <= '0;
            b_base_q <= '0;
            c_base_q <= '0;
            i_q      <= '0;
            j_q      <= '0;
            t_q      <= '0;
            acc_q    <= '0;
            opa_q    <= '0;
        end else begin
            state_q  <= state_d;
            start_q  <= bus.i_start;
            busy_q   <= busy_d;
            done_q   <= done_d;
            read_q   <= read_d;
            write_q  <= write_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            m_q      <= m_d;
            k_q      <= k_d;
            n_q      <= n_d;
            a_base_q <= a_base_d;
            b_base_q <= b_base_d;
            c_base_q <= c_base_d;
            i_q      <= i_d;
            j_q      <= j_d;
            t_q      <= t_d;
            acc_q    <= acc_d;
            opa_q    <= opa_d;
        end
    end

    assign bus.o_busy       = busy_q;
    assign bus.o_done       = done_q;
    assign bus.o_dram_read  = read_q;
    assign bus.o_dram_write = write_q;
    assign bus.o_dram_addr  = addr_q;
    assign bus.o_dram_wdata = wdata_q;
endmodule
